// File: rtl/cpu_bus_timing.sv
// ============================================================================
// cpu_bus_timing
// ----------------------------------------------------------------------------
// Timing front-end for the Z80-compatible CPU core. It does two jobs:
//   1. It derives the core's positive and negative phase clock enables
//      (cep/cen) from the master clock with a programmable divider. A turbo
//      mode halves the T-state length.
//   2. It drives the core's wait_n. Wait states are inserted per bus-cycle
//      type (opcode fetch, memory, I/O). An external hold request (video
//      contention) can stretch memory cycles further.
//
// Parameters:
//   DIV       master clocks per T-state in normal mode (even, >= 4)
//   M1_WAIT   extra T-states on opcode-fetch memory cycles
//   MEM_WAIT  extra T-states on other memory read/write cycles
//   IO_WAIT   extra T-states on I/O cycles
//   WAITW     width of the wait-state down-counter (all *_WAIT < 2**WAITW)
//
// Ports:
//   clock       in   master clock; all logic runs on its rising edge
//   reset       in   synchronous, active-high
//   turbo       in   1 = T-state is DIV/2 master clocks (taken at period wrap)
//   hold        in   contention request; stretches memory cycles while high
//   mreq_n      in   CPU memory request
//   iorq_n      in   CPU I/O request
//   m1_n        in   CPU opcode fetch / interrupt acknowledge
//   rfsh_n      in   CPU refresh
//   cep         out  positive-phase enable, one master clock wide
//   cen         out  negative-phase enable, one master clock wide
//   wait_n      out  to CPU wait_n, active low, registered
//   busy        out  high while a bus cycle is being tracked
//   wait_count  out  [15:0] wait statistics (only with CPU_WAIT_STATS_EN)
//
// Build option:
//   CPU_WAIT_STATS_EN  when defined, this adds wait_count. wait_count counts
//                      the cen pulses seen with wait_n low and saturates at
//                      16'hFFFF. When undefined, the port and the counter
//                      are absent.
//
// FSM states:
//   state | meaning
//   IDLE  | no bus cycle tracked, waiting for a registered strobe fall
//   COUNT | wait_n low, down-counter decrementing on each cen
//   HOLD  | wait states done, memory cycle stretched while hold is high
//   DONE  | wait_n released, waiting for mreq_n and iorq_n to return high
// ============================================================================
module cpu_bus_timing #(
    parameter int DIV      = 4,
    parameter int M1_WAIT  = 0,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int WAITW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        turbo,
    input  logic        hold,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic        cep,
    output logic        cen,
    output logic        wait_n,
    output logic        busy
`ifdef CPU_WAIT_STATS_EN
    ,
    output logic [15:0] wait_count
`endif
);

    // ------------------------------------------------------------------
    // Phase divider
    // ------------------------------------------------------------------
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] LAST_N = PW'(DIV - 1);
    localparam logic [PW-1:0] LAST_T = PW'(DIV / 2 - 1);
    localparam logic [PW-1:0] HALF_N = PW'(DIV / 2);
    localparam logic [PW-1:0] HALF_T = PW'(DIV / 4);
    localparam logic [PW-1:0] PH_ONE = PW'(1);

    logic [PW-1:0] ph;
    logic          turbo_q;
    logic [PW-1:0] ph_last;
    logic [PW-1:0] ph_half;
    logic          upd;

    always_comb begin
        ph_last = turbo_q ? LAST_T : LAST_N;
        ph_half = turbo_q ? HALF_T : HALF_N;
    end

    // upd marks the edge that raises cen. wait_n is only allowed to move on
    // this edge, so the core always samples a level that is one clock old.
    assign upd = (ph == ph_half);

    always_ff @(posedge clock) begin
        if (reset) begin
            ph      <= '0;
            turbo_q <= 1'b0;
            cep     <= 1'b0;
            cen     <= 1'b0;
        end else begin
            cep <= (ph == '0);
            cen <= (ph == ph_half);
            // turbo is taken only at the wrap, so the period that is running
            // always finishes at its old length.
            if (ph == ph_last) begin
                ph      <= '0;
                turbo_q <= turbo;
            end else begin
                ph <= ph + PH_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus strobe capture and cycle-start detection
    // ------------------------------------------------------------------
    // The strobes are registered once. Edge detection uses that stage and a
    // delayed copy of it, so the FSM never looks at an unregistered strobe.
    logic mreq_q;
    logic iorq_q;
    logic m1_q;
    logic rfsh_q;
    logic mreq_d;
    logic iorq_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            mreq_q <= 1'b1;
            iorq_q <= 1'b1;
            m1_q   <= 1'b1;
            rfsh_q <= 1'b1;
            mreq_d <= 1'b1;
            iorq_d <= 1'b1;
        end else begin
            mreq_q <= mreq_n;
            iorq_q <= iorq_n;
            m1_q   <= m1_n;
            rfsh_q <= rfsh_n;
            mreq_d <= mreq_q;
            iorq_d <= iorq_q;
        end
    end

    logic start_mem;
    logic start_io;

    // Refresh cycles never wait. An iorq_n fall with m1_n low is an
    // interrupt acknowledge, and the core already inserts its own waits.
    assign start_mem = mreq_d & ~mreq_q & rfsh_q;
    assign start_io  = iorq_d & ~iorq_q & m1_q;

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WAITW-1:0] M1_LD   = WAITW'(M1_WAIT);
    localparam logic [WAITW-1:0] MEM_LD  = WAITW'(MEM_WAIT);
    localparam logic [WAITW-1:0] IO_LD   = WAITW'(IO_WAIT);
    localparam logic [WAITW-1:0] CNT_ONE = WAITW'(1);

    logic [1:0]       st;
    logic [1:0]       st_nx;
    logic [WAITW-1:0] cnt;
    logic [WAITW-1:0] cnt_nx;
    logic             cyc_mem;
    logic             mem_nx;
    logic [WAITW-1:0] load_val;
    logic             wait_low_nx;

    // A memory start takes priority if both strobes fall in the same clock.
    always_comb begin
        if (start_mem) begin
            load_val = m1_q ? MEM_LD : M1_LD;
        end else begin
            load_val = IO_LD;
        end
    end

    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        mem_nx = cyc_mem;
        case (st)
            S_IDLE: begin
                // Any start seen outside IDLE is ignored until DONE -> IDLE.
                if (start_mem || start_io) begin
                    cnt_nx = load_val;
                    mem_nx = start_mem;
                    if ((load_val == '0) && (!hold || !start_mem)) begin
                        st_nx = S_DONE;
                    end else begin
                        st_nx = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                // The check for zero comes before the decrement, so the
                // counter can never wrap.
                if (cnt == '0) begin
                    st_nx = (hold && cyc_mem) ? S_HOLD : S_DONE;
                end else if (cen) begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (!hold || !cyc_mem) begin
                    st_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (mreq_q && iorq_q) begin
                    st_nx = S_IDLE;
                end
            end
            default: begin
                st_nx = S_IDLE;
            end
        endcase
    end

    assign wait_low_nx = (st_nx == S_COUNT) || (st_nx == S_HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            st      <= S_IDLE;
            cnt     <= '0;
            cyc_mem <= 1'b0;
            wait_n  <= 1'b1;
        end else begin
            st      <= st_nx;
            cnt     <= cnt_nx;
            cyc_mem <= mem_nx;
            if (upd) begin
                wait_n <= ~wait_low_nx;
            end
        end
    end

    assign busy = (st != S_IDLE);

    // ------------------------------------------------------------------
    // Optional wait statistics
    // ------------------------------------------------------------------
`ifdef CPU_WAIT_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_count <= 16'h0000;
        end else if (cen && !wait_n && (wait_count != 16'hFFFF)) begin
            wait_count <= wait_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_bus_timing.sv
// Bench for cpu_bus_timing. It builds two instances that share all inputs:
// dut_a (DIV=4, M1_WAIT=3, MEM_WAIT=0, IO_WAIT=1) and dut_b (DIV=4,
// M1_WAIT=0, MEM_WAIT=0, IO_WAIT=3). Define CPU_WAIT_STATS_EN to also check
// the wait statistics.
module tb_cpu_bus_timing;

    logic clock = 1'b0;
    logic reset;
    logic turbo;
    logic hold;
    logic mreq_n;
    logic iorq_n;
    logic m1_n;
    logic rfsh_n;

    logic cep_a, cen_a, wait_a, busy_a;
    logic cep_b, cen_b, wait_b, busy_b;
`ifdef CPU_WAIT_STATS_EN
    logic [15:0] wc_a;
    logic [15:0] wc_b;
`endif

    always #5 clock = ~clock;

    cpu_bus_timing #(
        .DIV(4), .M1_WAIT(3), .MEM_WAIT(0), .IO_WAIT(1), .WAITW(4)
    ) dut_a (
        .clock(clock), .reset(reset), .turbo(turbo), .hold(hold),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .cep(cep_a), .cen(cen_a), .wait_n(wait_a), .busy(busy_a)
`ifdef CPU_WAIT_STATS_EN
        , .wait_count(wc_a)
`endif
    );

    cpu_bus_timing #(
        .DIV(4), .M1_WAIT(0), .MEM_WAIT(0), .IO_WAIT(3), .WAITW(4)
    ) dut_b (
        .clock(clock), .reset(reset), .turbo(turbo), .hold(hold),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .cep(cep_b), .cen(cen_b), .wait_n(wait_b), .busy(busy_b)
`ifdef CPU_WAIT_STATS_EN
        , .wait_count(wc_b)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_edge   = 0;

    typedef struct {
        logic turbo;
        logic cep;
        logic cen;
    } ph_vec_t;

    typedef struct {
        logic mreq_n;
        logic iorq_n;
        logic m1_n;
        logic rfsh_n;
        logic hold;
        int   low_a;
        int   low_b;
        logic busy;
    } cyc_vec_t;

    ph_vec_t  pv[16];
    cyc_vec_t cv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        n_edge++;
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        rfsh_n = 1'b1;
        hold   = 1'b0;
    endtask

    // After this returns, the next edge is edge 1 with reset low.
    task automatic do_reset();
        bus_idle();
        turbo = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_cep", cep_a, 1'b0);
        chk("reset_cen", cen_a, 1'b0);
        chk("reset_wait_n", wait_a, 1'b1);
        chk("reset_busy", busy_a, 1'b0);
        reset  = 1'b0;
        n_edge = 0;
    endtask

    // Drives one bus cycle for 40 clocks and counts the cen pulses that the
    // core would see with wait_n low. It then releases the strobes.
    task automatic run_cycle(input int idx);
        int la;
        int lb;
        la = 0;
        lb = 0;
        repeat (3) tick();
        mreq_n = cv[idx].mreq_n;
        iorq_n = cv[idx].iorq_n;
        m1_n   = cv[idx].m1_n;
        rfsh_n = cv[idx].rfsh_n;
        hold   = cv[idx].hold;
        repeat (40) begin
            tick();
            if (cen_a && !wait_a) la++;
            if (cen_b && !wait_b) lb++;
        end
        chk($sformatf("cyc%0d_low_cens_a", idx), la, cv[idx].low_a);
        chk($sformatf("cyc%0d_low_cens_b", idx), lb, cv[idx].low_b);
        chk($sformatf("cyc%0d_busy_a", idx), busy_a, cv[idx].busy);
        chk($sformatf("cyc%0d_busy_b", idx), busy_b, cv[idx].busy);
        chk($sformatf("cyc%0d_wait_end_a", idx), wait_a, 1'b1);
        chk($sformatf("cyc%0d_wait_end_b", idx), wait_b, 1'b1);
        bus_idle();
        repeat (2) tick();
        chk($sformatf("cyc%0d_busy_clr_a", idx), busy_a, 1'b0);
        chk($sformatf("cyc%0d_busy_clr_b", idx), busy_b, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Edges 1..5 run at period 4. turbo rises after edge 5, while the
        // phase is 1. That period still ends at edge 8, and period 2 starts.
        pv[0]  = '{1'b0, 1'b1, 1'b0};
        pv[1]  = '{1'b0, 1'b0, 1'b0};
        pv[2]  = '{1'b0, 1'b0, 1'b1};
        pv[3]  = '{1'b0, 1'b0, 1'b0};
        pv[4]  = '{1'b0, 1'b1, 1'b0};
        pv[5]  = '{1'b1, 1'b0, 1'b0};
        pv[6]  = '{1'b1, 1'b0, 1'b1};
        pv[7]  = '{1'b1, 1'b0, 1'b0};
        pv[8]  = '{1'b1, 1'b1, 1'b0};
        pv[9]  = '{1'b1, 1'b0, 1'b1};
        pv[10] = '{1'b1, 1'b1, 1'b0};
        pv[11] = '{1'b1, 1'b0, 1'b1};
        pv[12] = '{1'b1, 1'b1, 1'b0};
        pv[13] = '{1'b1, 1'b0, 1'b1};
        pv[14] = '{1'b1, 1'b1, 1'b0};
        pv[15] = '{1'b1, 1'b0, 1'b1};

        //          mreq  iorq  m1    rfsh  hold  low_a low_b busy
        cv[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1,    3,    1'b1}; // I/O
        cv[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1,    3,    1'b1}; // I/O, hold ignored
        cv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3,    0,    1'b1}; // opcode fetch
        cv[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0,    0,    1'b1}; // memory read
        cv[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0,    0,    1'b0}; // refresh with hold
        cv[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0,    0,    1'b0}; // interrupt ack

        // Divider at normal speed: cep after edges 1,5,9..., cen after 3,7,11...
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk($sformatf("div_cep_e%0d", k), cep_a, (k % 4) == 1);
            chk($sformatf("div_cen_e%0d", k), cen_a, (k % 4) == 3);
        end

        // Turbo switch in the middle of a period.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            turbo = pv[i].turbo;
            tick();
            chk($sformatf("turbo_cep_e%0d", i + 1), cep_a, pv[i].cep);
            chk($sformatf("turbo_cen_e%0d", i + 1), cen_a, pv[i].cen);
        end
        turbo = 1'b0;

        // Bus-cycle type table.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_cycle(i);
        end

        // Contention: memory read with MEM_WAIT=0, hold high for edges 5..14.
        do_reset();
        repeat (4) tick();
        mreq_n = 1'b0;
        hold   = 1'b1;
        repeat (2) tick();
        chk("hold_wait_before_cen", wait_a, 1'b1);
        chk("hold_busy", busy_a, 1'b1);
        tick();
        chk("hold_first_cen", cen_a, 1'b1);
        chk("hold_first_wait_a", wait_a, 1'b0);
        chk("hold_first_wait_b", wait_b, 1'b0);
        repeat (4) tick();
        chk("hold_mid_cen", cen_a, 1'b1);
        chk("hold_mid_wait", wait_a, 1'b0);
        repeat (3) tick();
        chk("hold_last_wait", wait_a, 1'b0);
        hold = 1'b0;
        tick();
        chk("hold_release_wait_a", wait_a, 1'b1);
        chk("hold_release_wait_b", wait_b, 1'b1);
        chk("hold_release_cen", cen_a, 1'b1);
        tick();
        mreq_n = 1'b1;
        tick();
        chk("hold_busy_done", busy_a, 1'b1);
        tick();
        chk("hold_busy_idle", busy_a, 1'b0);

        // Reset while dut_a is counting an opcode fetch with 2 waits left.
        do_reset();
        mreq_n = 1'b0;
        m1_n   = 1'b0;
        repeat (4) tick();
        chk("rst_mid_pre_wait", wait_a, 1'b0);
        chk("rst_mid_pre_busy", busy_a, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_mid_wait", wait_a, 1'b1);
        chk("rst_mid_busy_a", busy_a, 1'b0);
        chk("rst_mid_busy_b", busy_b, 1'b0);
        chk("rst_mid_cep", cep_a, 1'b0);
        chk("rst_mid_cen", cen_a, 1'b0);
`ifdef CPU_WAIT_STATS_EN
        chk("stats_reset_a", wc_a, 16'd0);
`endif
        bus_idle();
        tick();
        reset = 1'b0;
`ifdef CPU_WAIT_STATS_EN
        for (int i = 0; i < 5; i++) begin
            run_cycle(0);
        end
        chk("stats_five_io_a", wc_a, 16'd5);
        chk("stats_five_io_b", wc_b, 16'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
